// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle arithmetic controller for the calculator.
// Add/sub/error cases finish in one cycle (ALU1); multiply (shift-add) and
// divide (restoring shift-subtract) iterate WIDTH cycles in ITER, then
// write back in FIN. done is a one-cycle pulse issued while back in IDLE.
//
// Handshake: a request is accepted on a rising edge where the FSM is IDLE
// and start=1; operands are captured on that edge. busy is high from that
// edge until the result is presented. done pulses for exactly one cycle,
// and that cycle is an IDLE cycle, so a start raised during done is taken
// immediately. A start while busy is dropped.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             err_ovf,
    output logic             err_neg,
    output logic             err_div0,
    output logic             err_op,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ALU1 = 2'd1,
        S_ITER = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [3:0] OP_PLUS  = 4'b1100;
    localparam logic [3:0] OP_MINUS = 4'b1101;
    localparam logic [3:0] OP_MULT  = 4'b1110;
    localparam logic [3:0] OP_DIV   = 4'b1111;

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // r_hi: product high half / partial remainder
    // r_lo: multiplier bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH+1:0] w_div_trial;
    logic             w_div_fits;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;
    logic             w_iter_start;

    // Single-cycle add/sub with carry/borrow in the top bit.
    assign w_add = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub = {1'b0, r_a} - {1'b0, r_b};

    // One shift-add step: add multiplicand when the current multiplier LSB
    // is set, then shift the {carry, hi, lo} chain right by one.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_trial = {1'b0, w_div_shift} - {2'b00, r_b};
    assign w_div_fits  = ~w_div_trial[WIDTH+1];
    assign w_div_hi    = w_div_fits ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_fits};

    // Divide by zero short-cuts through ALU1 instead of iterating.
    assign w_iter_start = (op == OP_MULT) || ((op == OP_DIV) && (operand_b != '0));

    assign o_dbg_state = r_state;

    // Control FSM with registered results, flags, busy and done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            result    <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_ovf   <= 1'b0;
            err_neg   <= 1'b0;
            err_div0  <= 1'b0;
            err_op    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= operand_a;
                        r_b     <= operand_b;
                        r_hi    <= '0;
                        r_lo    <= operand_a;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= w_iter_start ? S_ITER : S_ALU1;
                    end
                end
                S_ALU1: begin
                    err_ovf   <= 1'b0;
                    err_neg   <= 1'b0;
                    err_div0  <= 1'b0;
                    err_op    <= 1'b0;
                    remainder <= '0;
                    case (r_op)
                        OP_PLUS: begin
                            result  <= w_add[WIDTH-1:0];
                            err_ovf <= w_add[WIDTH];
                        end
                        OP_MINUS: begin
                            result  <= w_sub[WIDTH-1:0];
                            err_neg <= w_sub[WIDTH];
                        end
                        OP_DIV: begin
                            result    <= '1;
                            remainder <= r_a;
                            err_div0  <= 1'b1;
                        end
                        default: begin
                            result <= '0;
                            err_op <= 1'b1;
                        end
                    endcase
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_ITER: begin
                    if (r_op == OP_MULT) begin
                        r_hi <= w_mul_hi;
                        r_lo <= w_mul_lo;
                    end else begin
                        r_hi <= w_div_hi;
                        r_lo <= w_div_lo;
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    result   <= r_lo;
                    err_neg  <= 1'b0;
                    err_div0 <= 1'b0;
                    err_op   <= 1'b0;
                    if (r_op == OP_MULT) begin
                        remainder <= '0;
                        err_ovf   <= (r_hi != '0);
                    end else begin
                        remainder <= r_hi;
                        err_ovf   <= 1'b0;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle arithmetic controller between the calculator key-entry FSM and the result display path. It accepts one operation request at a time (op code plus two unsigned operands) and runs add/subtract in a single cycle. Multiply runs as an iterative shift-add and divide as a restoring shift-subtract, each over WIDTH cycles. It returns the result with a one-cycle done pulse and sticky error flags, so the upstream FSM only issues start and waits for done.

Parameters:
WIDTH, 16, operand/result width in bits; also the iteration count for multiply and divide.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-low reset: sampled on posedge clk, 0 = reset.
start  in  1  request strobe; sampled only when busy=0.
op  in  4  operation code: 4'b1100 plus, 4'b1101 minus, 4'b1110 mult, 4'b1111 div; any other value is invalid.
operand_a  in  WIDTH  first operand (dividend / minuend), unsigned.
operand_b  in  WIDTH  second operand (divisor / subtrahend), unsigned.
result  out  WIDTH  sum / difference / product low half / quotient.
remainder  out  WIDTH  divide remainder; 0 for all other ops.
busy  out  1  high while an accepted operation is in progress.
done  out  1  single-cycle completion pulse.
err_ovf  out  1  add carry-out, or product exceeds WIDTH bits.
err_neg  out  1  subtract borrow (operand_b > operand_a).
err_div0  out  1  divide by zero.
err_op  out  1  invalid op code.

Behaviour:
- Reset (reset=0 at posedge):
  - state -> IDLE.
  - result, remainder, busy, done and all err_* -> 0.
  - Any in-flight operation is aborted with no done pulse.
  - start in the same cycle is ignored.
- States: IDLE, ALU1 (single-cycle ops and error short-cuts), ITER (mult/div loop), FIN (mult/div write-back).
- Accept:
  - Condition: posedge T0 with state=IDLE and start=1.
  - Actions: latch op, operand_a and operand_b internally; busy=1 from T0.
  - Operands may change after T0 without effect.
- start with busy=1 is ignored; no queueing.
- Add/sub/invalid/div0: IDLE -> ALU1 -> IDLE.
  - Outputs update at T0+1; done=1 and busy=0 during the cycle after T0+1.
  - Latency is 1 cycle.
- Mult/div (divisor nonzero): IDLE -> ITER for exactly WIDTH cycles -> FIN -> IDLE.
  - Outputs update at edge T0+WIDTH+1, with done pulse and busy=0 in the following cycle.
  - Latency is WIDTH+1 = 17 cycles at default.
- Back-to-back: done is asserted while state=IDLE, so a start in the done cycle is accepted.
- Arithmetic (all unsigned, modulo 2^WIDTH):
  - plus: result = a+b; err_ovf = carry out.
  - minus: result = a-b; err_neg = borrow.
  - mult: 2*WIDTH-bit product; result = low half; err_ovf = (high half != 0).
  - div: result = a/b, remainder = a%b.
  - div with b=0: no iteration; result = all ones, remainder = a, err_div0=1.
  - invalid op: result = 0, remainder = 0, err_op=1.
- Output hold:
  - result, remainder and all err_* change only at a completion edge.
  - All four flags are rewritten at each completion; flags not raised by that op clear to 0.
  - All outputs hold until the next completion or reset.
- done is never high for more than one consecutive cycle unless a new op completes in the next cycle.

Test Plan:
- Reset held low 3 cycles, then released -> all outputs 0, busy=0. start=1 during reset -> no done.
- Plus 1234+4321 at T0 -> T0+1: result=5555, done=1 one cycle, no flags. Then plus 65535+1 -> result=0, err_ovf=1.
- Minus 5-7 -> result=65534, err_neg=1, latency 1. Follow with back-to-back plus 2+2 started in the done cycle -> result=4, err_neg=0.
- Mult 300*300 -> busy high 17 cycles; result=24464 (90000 mod 65536), err_ovf=1. Mult 255*255 -> 65025, no flags.
- Div 1000/7 -> T0+17: result=142, remainder=6.
  - Div 9/0 -> T0+1: result=65535, remainder=9, err_div0=1.
  - op=4'b0011 -> result=0, err_op=1.
- Mult 300*300 started, second start at T0+5 -> ignored, single done at T0+17. Reset low at T0+8 of another mult -> no done, outputs 0, next start accepted normally.
